// File: rtl/iob_wishbone2iob_pkg.sv
// Shared types for the Wishbone-to-IOb bridge: FSM state encoding and lane-width helper.
// Purely declarative; no logic, no latency, no flow control.
package iob_wishbone2iob_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        ERR  = 2'd3
    } state_e;

    function automatic int wb_sel_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_wb_timeout.sv
// REQ-phase watchdog: counts stalled cycles, flags the cycle whose increment reaches 2**W-1.
// Present only in IOB_WB2IOB_TIMEOUT_EN builds; single-cycle flag, no backpressure.
`ifdef IOB_WB2IOB_TIMEOUT_EN
module iob_wb_timeout #(
    parameter int W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);
    localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the increment that would land on the limit, so the REQ phase lasts exactly 2**W-1 cycles.
    assign tc_o = inc_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave -> single outstanding IOb request; ack >= 2 cycles after strobe, request held until ready_i.
// Optional REQ timeout with wb_error_o under macro IOB_WB2IOB_TIMEOUT_EN.
module iob_wishbone2iob
    import iob_wishbone2iob_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [ADDR_W-1:0]             wb_addr_i,
    input  logic [wb_sel_w(DATA_W)-1:0]   wb_select_i,
    input  logic                          wb_we_i,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic [DATA_W-1:0]             wb_data_i,
    output logic                          wb_ack_o,
    output logic                          wb_error_o,
    output logic [DATA_W-1:0]             wb_data_o,
    output logic                          valid_o,
    output logic [ADDR_W-1:0]             address_o,
    output logic [DATA_W-1:0]             wdata_o,
    output logic [wb_sel_w(DATA_W)-1:0]   wstrb_o,
    input  logic [DATA_W-1:0]             rdata_i,
    input  logic                          ready_i
);
    localparam int SEL_W = wb_sel_w(DATA_W);

    state_e              state_q;
    logic                abort_q;
    logic                ack_q;
    logic                valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [SEL_W-1:0]    wstrb_q;
    logic [DATA_W-1:0]   rdata_q;

`ifdef IOB_WB2IOB_TIMEOUT_EN
    logic err_q;
    logic timeout;

    iob_wb_timeout #(
        .W(TIMEOUT_W)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_i (arst_i),
        .clr_i (state_q != REQ),
        .inc_i ((state_q == REQ) && !ready_i),
        .tc_o  (timeout)
    );

    assign wb_error_o = err_q;
`else
    logic timeout;

    // REQ never times out here; the width parameter only matters for timeout builds.
    assign timeout    = (TIMEOUT_W < 0);
    assign wb_error_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
`ifdef IOB_WB2IOB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef IOB_WB2IOB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        addr_q  <= wb_addr_i;
                        wdata_q <= wb_data_i;
                        wstrb_q <= wb_we_i ? wb_select_i : '0;
                        valid_q <= 1'b1;
                        abort_q <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // A master abort cannot cancel the IOb side; remember it and swallow the response.
                    if (!wb_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        if (abort_q || !wb_cyc_i) begin
                            state_q <= IDLE;
                        end else begin
                            if (wstrb_q == '0) begin
                                rdata_q <= rdata_i;
                            end
                            ack_q   <= 1'b1;
                            state_q <= RSP;
                        end
                    end else if (timeout) begin
                        valid_q <= 1'b0;
                        if (abort_q || !wb_cyc_i) begin
                            state_q <= IDLE;
                        end else begin
`ifdef IOB_WB2IOB_TIMEOUT_EN
                            err_q   <= 1'b1;
`endif
                            state_q <= ERR;
                        end
                    end
                end
                RSP:     state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_data_o = rdata_q;
    assign valid_o   = valid_q;
    assign address_o = addr_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;

endmodule
